// File: rtl/lz77_hash_table_ctrl_pkg.sv
// ============================================================================
// Module   : lz77_hash_table_ctrl_pkg
// Purpose  : Shared widths, state encoding and empty-slot value for the
//            LZ77 hash-table controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lz77_hash_table_ctrl_pkg;

  localparam int POS_W = 14;
  localparam logic [POS_W-1:0] EMPTY_POS = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_CLR_WAIT = 2'd1,
    ST_CLR      = 2'd2
  } ht_state_e;

endpackage

`default_nettype wire

// File: rtl/lz77_hash_table_ctrl.sv
// ============================================================================
// Module   : lz77_hash_table_ctrl
// Purpose  : Hash-table lookup/insert controller with full-table clear sweep;
//            LZ77_HT_CLEAR_ON_RESET_EN adds an automatic sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lz77_hash_table_ctrl
  import lz77_hash_table_ctrl_pkg::*;
#(
  parameter int HASH_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HASH_BITS-1:0] in_hash,
  input  logic [POS_W-1:0]     in_pos,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POS_W-1:0]     out_prev_pos,
  output logic                 out_hit,
  output logic [POS_W-1:0]     out_dist,
  output logic [POS_W-1:0]     out_pos,
  input  logic                 clr_req,
  output logic                 clr_done,
  output logic [HASH_BITS-1:0] ram_addr,
  output logic                 ram_wen,
  output logic [POS_W-1:0]     ram_wdata,
  output logic                 ram_ren,
  input  logic [POS_W-1:0]     ram_rdata
);

`ifdef LZ77_HT_CLEAR_ON_RESET_EN
  localparam logic BOOT_CLR_RST = 1'b1;
`else
  localparam logic BOOT_CLR_RST = 1'b0;
`endif

  ht_state_e            r_state;
  logic [HASH_BITS-1:0] r_clr_cnt;
  logic                 r_out_valid;
  logic [POS_W-1:0]     r_out_pos;
  logic                 r_clr_done;
  logic                 r_boot_clr;

  logic w_drain_ok;
  logic w_accept;
  logic w_in_clr;

  assign w_drain_ok = !r_out_valid || out_ready;
  assign w_in_clr   = (r_state == ST_CLR);
  assign in_ready   = rstn && (r_state == ST_RUN) && !r_boot_clr && w_drain_ok && !clr_req;
  assign w_accept   = in_valid && in_ready;

  // Read-before-write insert: the RAM returns the old slot while storing in_pos.
  assign ram_addr  = w_in_clr ? r_clr_cnt : in_hash;
  assign ram_ren   = w_accept;
  assign ram_wen   = w_accept || w_in_clr;
  assign ram_wdata = w_in_clr ? EMPTY_POS : in_pos;

  // RAM holds rdata while ren is low, so the result stays stable during stalls.
  assign out_prev_pos = ram_rdata;
  assign out_hit      = (ram_rdata != EMPTY_POS);
  assign out_dist     = r_out_pos - ram_rdata;
  assign out_pos      = r_out_pos;
  assign out_valid    = r_out_valid;
  assign clr_done     = r_clr_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_RUN;
      r_clr_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_pos   <= '0;
      r_clr_done  <= 1'b0;
      r_boot_clr  <= BOOT_CLR_RST;
    end else begin
      r_clr_done <= 1'b0;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_pos   <= in_pos;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (r_boot_clr) begin
            r_boot_clr <= 1'b0;
            r_state    <= ST_CLR;
          end else if (clr_req) begin
            r_state <= w_drain_ok ? ST_CLR : ST_CLR_WAIT;
          end
        end
        ST_CLR_WAIT: begin
          if (w_drain_ok) r_state <= ST_CLR;
        end
        ST_CLR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (&r_clr_cnt) begin
            r_clr_done <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lz77_hash_table_ctrl.sv
// ============================================================================
// Module   : tb_lz77_hash_table_ctrl
// Purpose  : Self-checking bench for lz77_hash_table_ctrl with a behavioural
//            read-first RAM and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lz77_hash_table_ctrl;
  import lz77_hash_table_ctrl_pkg::*;

  localparam int HASH_BITS = 12;
  localparam int DEPTH     = 1 << HASH_BITS;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [HASH_BITS-1:0] in_hash = '0;
  logic [POS_W-1:0]     in_pos = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [POS_W-1:0]     out_prev_pos;
  logic                 out_hit;
  logic [POS_W-1:0]     out_dist;
  logic [POS_W-1:0]     out_pos;
  logic                 clr_req = 1'b0;
  logic                 clr_done;
  logic [HASH_BITS-1:0] ram_addr;
  logic                 ram_wen;
  logic [POS_W-1:0]     ram_wdata;
  logic                 ram_ren;
  logic [POS_W-1:0]     ram_rdata = '0;

  lz77_hash_table_ctrl #(.HASH_BITS(HASH_BITS)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_hash(in_hash), .in_pos(in_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_prev_pos(out_prev_pos),
    .out_hit(out_hit), .out_dist(out_dist), .out_pos(out_pos),
    .clr_req(clr_req), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port read-first RAM, powered up with non-zero garbage.
  logic [POS_W-1:0] mem [DEPTH];
  bit ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 14'h1555;
      ram_inited <= 1'b1;
    end else begin
      if (ram_ren) ram_rdata <= mem[ram_addr];
      if (ram_wen) mem[ram_addr] <= ram_wdata;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] prev;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always begin
    @(negedge clk);
    #2;
    if (rstn && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got pos=%0d prev=%0d, expected no result", out_pos, out_prev_pos);
      end else begin
        e = sb.pop_front();
        if (out_pos !== e.pos || out_prev_pos !== e.prev || out_hit !== (e.prev != 0) ||
            out_dist !== POS_W'(e.pos - e.prev)) begin
          errors++;
          $display("FAIL result: got pos=%0d prev=%0d hit=%0b dist=%0d, expected pos=%0d prev=%0d hit=%0b dist=%0d",
                   out_pos, out_prev_pos, out_hit, out_dist,
                   e.pos, e.prev, (e.prev != 0), POS_W'(e.pos - e.prev));
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [HASH_BITS-1:0] h, input logic [POS_W-1:0] p,
                      input logic [POS_W-1:0] ex);
    int n = 0;
    in_valid = 1'b1;
    in_hash  = h;
    in_pos   = p;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for hash 0x%0h, expected accept within 100 cycles", h);
    end else begin
      sb.push_back('{pos: p, prev: ex});
      acc_cyc = cyc;
    end
    @(negedge clk);
  endtask

  // Called at the falling edge where the sweep sits at address 0.
  task automatic sweep_check(input bit poke_clr);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (!(ram_wen && !ram_ren && ram_wdata == EMPTY_POS && ram_addr == HASH_BITS'(i) &&
            !in_ready && !out_valid && !clr_done))
        bad++;
      clr_req = (poke_clr && i == 100);
      @(negedge clk);
    end
    clr_req = 1'b0;
    chk("clr_sweep_bad_cycles", 64'(bad), 64'd0);
    #1;
    chk("clr_done_pulse", 64'(clr_done), 64'd1);
    @(negedge clk);
    #1;
    chk("clr_done_low", 64'(clr_done), 64'd0);
    chk("ready_after_clr", 64'(in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [HASH_BITS-1:0] h;
    logic [POS_W-1:0]     p;
    logic [POS_W-1:0]     ex;
  } vec_t;
  vec_t vt[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{12'h123, 14'd5, 14'd0};
    vt[1] = '{12'h123, 14'd9, 14'd5};
    for (int i = 0; i < 8; i++) vt[2+i] = '{12'h0AB, POS_W'(i + 1), POS_W'(i)};
    vt[10] = '{12'h7FF, 14'd3,     14'd0};
    vt[11] = '{12'h7FF, 14'd16380, 14'd3};
    vt[12] = '{12'h7FF, 14'd2,     14'd16380};

    // Reset behaviour
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_clr_done", 64'(clr_done), 64'd0);
    chk("rst_out_pos", 64'(out_pos), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
`ifdef LZ77_HT_CLEAR_ON_RESET_EN
    #1;
    chk("boot_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    sweep_check(1'b0);
`else
    #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_no_write", 64'(ram_wen), 64'd0);
    @(negedge clk);
`endif

    // Explicit clear; a request alongside clr_req must be refused, and a
    // second clr_req mid-sweep must not restart it.
    clr_req  = 1'b1;
    in_valid = 1'b1;
    in_hash  = 12'h055;
    in_pos   = 14'd77;
    #1;
    chk("clr_req_blocks_ready", 64'(in_ready), 64'd0);
    chk("clr_req_no_read", 64'(ram_ren), 64'd0);
    @(negedge clk);
    clr_req  = 1'b0;
    in_valid = 1'b0;
    sweep_check(1'b1);

    // Table-driven lookups, back-to-back with out_ready high
    out_ready = 1'b1;
    begin
      int first_cyc;
      send(vt[0].h, vt[0].p, vt[0].ex);
      first_cyc = acc_cyc;
      for (int i = 1; i < 13; i++) send(vt[i].h, vt[i].p, vt[i].ex);
      chk("throughput_cycles", 64'(acc_cyc - first_cyc), 64'd12);
    end
    drain();

    // Stall: held result, blocked input, no RAM traffic
    out_ready = 1'b0;
    send(12'h200, 14'd50, 14'd0);
    in_valid = 1'b1;
    in_hash  = 12'h201;
    in_pos   = 14'd55;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ctrl", {60'd0, in_ready, ram_ren, ram_wen, out_valid}, 64'b0001);
      chk("stall_out", {out_pos, out_prev_pos, out_dist, 1'b0, out_hit}, {14'd50, 14'd0, 14'd50, 2'b00});
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(12'h200, 14'd60, 14'd50);
    drain();

    // Clear requested while a result is stalled
    out_ready = 1'b0;
    send(12'h300, 14'd70, 14'd0);
    in_valid = 1'b0;
    clr_req  = 1'b1;
    #1;
    chk("clr_wait_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("clr_wait_hold", {61'd0, in_ready, ram_wen, out_valid}, 64'b001);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    sweep_check(1'b0);
    send(12'h123, 14'd20, 14'd0);
    send(12'h200, 14'd21, 14'd0);
    send(12'h123, 14'd22, 14'd20);
    drain();

    // Reset in the middle of a sweep
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("sweep_addr_100", 64'(ram_addr), 64'd100);
    rstn = 1'b0;
    #1;
    chk("midclr_rst_ready", 64'(in_ready), 64'd0);
    chk("midclr_rst_valid", 64'(out_valid), 64'd0);
    chk("midclr_rst_done", 64'(clr_done), 64'd0);
    chk("midclr_rst_pos", 64'(out_pos), 64'd0);
    chk("midclr_rst_wen", 64'(ram_wen), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
`ifdef LZ77_HT_CLEAR_ON_RESET_EN
    #1;
    chk("midclr_boot_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    sweep_check(1'b0);
`else
    #1;
    chk("midclr_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    chk("midclr_no_resume", 64'(ram_wen), 64'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lz77_hash_table_ctrl.md
LZ77_HASH_TABLE_CTRL -- requirements
Module: lz77_hash_table_ctrl

Interface
REQ-001 Parameter HASH_BITS, default 12, hash-table address width; table depth is 2^HASH_BITS.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  lookup/insert request valid.
REQ-005 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-006 in_hash  in  HASH_BITS  hash of current 3-byte string.
REQ-007 in_pos  in  14  current position; 1-based; 0 is never a legal position.
REQ-008 out_valid  out  1  lookup result valid.
REQ-009 out_ready  in  1  consumer accepts result.
REQ-010 out_prev_pos  out  14  previous position stored under in_hash; 0 means empty.
REQ-011 out_hit  out  1  out_prev_pos != 0.
REQ-012 out_dist  out  14  (out_pos - out_prev_pos) mod 2^14.
REQ-013 out_pos  out  14  in_pos of the request being answered.
REQ-014 clr_req  in  1  single-cycle pulse requesting a full table clear.
REQ-015 clr_done  out  1  one-cycle pulse when the clear sweep completes.
REQ-016 ram_addr  out  HASH_BITS, ram_wen out 1, ram_wdata out 14, ram_ren out 1, ram_rdata in 14: hash-table RAM port (single port, read-first, 1-cycle read latency, rdata held while ren is low).

Function
REQ-017 States SHALL be RUN, CLR_WAIT, CLR; reset state RUN.
REQ-018 In RUN, in_ready SHALL be (!out_valid || out_ready) && !clr_req.
REQ-019 On accept, the same cycle SHALL drive ram_addr=in_hash, ram_ren=1, ram_wen=1, ram_wdata=in_pos (read-before-write insert).
REQ-020 out_valid SHALL rise the cycle after accept; out_prev_pos SHALL equal ram_rdata; out_pos SHALL be in_pos registered at accept.
REQ-021 Sustained throughput SHALL be one request per cycle with out_ready held high.
REQ-022 With out_valid=1 and out_ready=0: no new accept, ram_ren=0, and all out_* SHALL stay stable.
REQ-023 Back-to-back requests to the same hash SHALL return the immediately preceding in_pos (no stale data).
REQ-024 out_hit SHALL be 1 exactly when out_prev_pos != 0; out_dist SHALL be a 14-bit wrap-around subtraction.
REQ-025 clr_req in RUN: go to CLR if out_valid=0 or out_ready=1 that cycle, else to CLR_WAIT; a request presented the same cycle SHALL NOT be accepted.
REQ-026 CLR_WAIT: in_ready=0; go to CLR when out_valid=0 or out_ready=1.
REQ-027 CLR: in_ready=0, ram_wen=1, ram_ren=0, ram_wdata=0, ram_addr=counter from 0 to 2^HASH_BITS-1, one address per cycle.
REQ-028 After writing the last address, assert clr_done for one cycle and return to RUN; counter wraps to 0.
REQ-029 clr_req during CLR_WAIT or CLR SHALL be ignored (no restart).
REQ-030 out_valid SHALL clear on consume and SHALL never be asserted in CLR.

Reset
REQ-031 rstn low: state RUN, out_valid=0, clr_done=0, counter=0, out_pos=0, in_ready=0 while asserted; RAM contents untouched.
REQ-032 Reset mid-CLR SHALL abort the sweep; a table clear is required again before reuse.

Configuration
REQ-033 Macro LZ77_HT_CLEAR_ON_RESET_EN defined: after rstn deasserts, SHALL enter CLR automatically (in_ready=0 for 2^HASH_BITS cycles, clr_done pulses).
REQ-034 Macro undefined: reset exits to RUN directly; table cleared only by clr_req.

Structure
REQ-035 Shared package SHALL hold POS_W=14, state encoding, and the empty-position constant 0.
REQ-036 No sub-module; the RAM is instantiated by the parent, not inside this block.

Verification
REQ-037 Insert hash 0x123 pos 5, then hash 0x123 pos 9 -> results prev 0 hit 0, then prev 5 hit 1 dist 4.
REQ-038 8 back-to-back requests, same hash, pos 1..8, out_ready=1 -> prev 0,1,..,7, one result per cycle.
REQ-039 out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, out_* unchanged, no RAM access.
REQ-040 clr_req with pending stalled result -> CLR_WAIT until consumed, then 4096 zero writes, clr_done at end; lookup of a previously stored hash returns prev 0.
REQ-041 pos 3 then 16380 on same hash, then pos 2 -> dist 16377, then (2-16380) mod 16384 = 6.
REQ-042 rstn asserted at sweep address 100 -> outputs at reset values; with macro defined, full sweep restarts after release.
